// File: rtl/data_mem_ctrl.sv
// Multi-cycle byte-addressable RV32 data memory with a valid/ready request port and a one-cycle response pulse.
// Define MEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses with an error response.
module data_mem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_BYTES  = 16384,
    parameter int LATENCY    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [2:0]            i_req_size,
    input  logic [31:0]           i_req_wdata,
    output logic                  o_resp_valid,
    output logic [31:0]           o_resp_rdata,
    output logic                  o_resp_err
);

    localparam int IDX_W = $clog2(MEM_BYTES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [2:0]            r_size;
    logic [31:0]           r_wdata;
    logic [7:0]            r_mem [MEM_BYTES];

    logic [1:0]            w_span;
    logic [ADDR_WIDTH:0]   w_last;
    logic                  w_rangeErr;
    logic                  w_sizeErr;
    logic                  w_misalign;
    logic                  w_err;
    logic                  w_done;
    logic [IDX_W-1:0]      w_base;
    logic [7:0]            w_rbyte [4];
    logic [31:0]           w_load;

    assign o_req_ready = (r_state == IDLE) && !i_rst;
    assign w_done      = (r_state == BUSY) && (r_cnt == '0);
    assign w_base      = r_addr[IDX_W-1:0];

    // w_span is the offset of the last byte touched; the range check runs one bit wider so high addresses cannot wrap.
    always_comb begin
        case (r_size[1:0])
            2'b00:   w_span = 2'd0;
            2'b01:   w_span = 2'd1;
            default: w_span = 2'd3;
        endcase
    end

    assign w_last     = {1'b0, r_addr} + {{(ADDR_WIDTH-1){1'b0}}, w_span};
    assign w_rangeErr = w_last >= (ADDR_WIDTH+1)'(MEM_BYTES);
    assign w_sizeErr  = (r_size == 3'b011) || (r_size[2:1] == 2'b11) || (r_size[2] && r_we);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign = ((r_size[1:0] == 2'b01) && r_addr[0]) ||
                        ((r_size[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err = w_sizeErr || w_rangeErr || w_misalign;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_rbyte[k] = r_mem[w_base + IDX_W'(k)];
        end
    end

    always_comb begin
        case (r_size)
            3'b000:  w_load = {{24{w_rbyte[0][7]}}, w_rbyte[0]};
            3'b001:  w_load = {{16{w_rbyte[1][7]}}, w_rbyte[1], w_rbyte[0]};
            3'b010:  w_load = {w_rbyte[3], w_rbyte[2], w_rbyte[1], w_rbyte[0]};
            3'b100:  w_load = {24'd0, w_rbyte[0]};
            3'b101:  w_load = {16'd0, w_rbyte[1], w_rbyte[0]};
            default: w_load = 32'd0;
        endcase
    end

    // Stores commit on the response edge, never while reset is dropping the access.
    always_ff @(posedge i_clk) begin
        if (w_done && r_we && !w_err && !i_rst) begin
            for (int k = 0; k < 4; k++) begin
                if (2'(k) <= w_span) begin
                    r_mem[w_base + IDX_W'(k)] <= r_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            o_resp_valid <= 1'b0;
            o_resp_rdata <= 32'd0;
            o_resp_err   <= 1'b0;
        end else begin
            o_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_we    <= i_req_we;
                        r_addr  <= i_req_addr;
                        r_size  <= i_req_size;
                        r_wdata <= i_req_wdata;
                        r_cnt   <= CNT_W'(LATENCY - 1);
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == '0) begin
                        o_resp_valid <= 1'b1;
                        o_resp_rdata <= (w_err || r_we) ? 32'd0 : w_load;
                        o_resp_err   <= w_err;
                        r_state      <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: vector table through a response scoreboard plus reset-abort sequence.
// Expectations for misaligned accesses follow MEM_MISALIGN_TRAP_EN.
module tb_data_mem_ctrl;

    localparam int ADDR_WIDTH = 32;
    localparam int MEM_BYTES  = 16384;
    localparam int LATENCY    = 2;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam logic        MIS_ERR = 1'b1;
    localparam logic [31:0] MIS_LW  = 32'h0000_0000;
    localparam logic [31:0] MIS_LH  = 32'h0000_0000;
`else
    localparam logic        MIS_ERR = 1'b0;
    localparam logic [31:0] MIS_LW  = 32'h55DE_AD77;
    localparam logic [31:0] MIS_LH  = 32'h0000_55DE;
`endif

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] expRd;
        logic        expErr;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  reqValid = 1'b0;
    logic                  reqReady;
    logic                  reqWe = 1'b0;
    logic [ADDR_WIDTH-1:0] reqAddr = '0;
    logic [2:0]            reqSize = 3'b000;
    logic [31:0]           reqWdata = 32'd0;
    logic                  respValid;
    logic [31:0]           respRdata;
    logic                  respErr;

    int   compared   = 0;
    int   mismatches = 0;
    int   cyc        = 0;
    exp_t sb[$];
    vec_t vecs[$];
    exp_t monExp;

    data_mem_ctrl #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .MEM_BYTES (MEM_BYTES),
        .LATENCY   (LATENCY)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (reqValid),
        .o_req_ready (reqReady),
        .i_req_we    (reqWe),
        .i_req_addr  (reqAddr),
        .i_req_size  (reqSize),
        .i_req_wdata (reqWdata),
        .o_resp_valid(respValid),
        .o_resp_rdata(respRdata),
        .o_resp_err  (respErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatches++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endfunction

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [2:0] size,
                                input logic [31:0] wdata, input logic [31:0] rd, input logic err);
        vec_t v;
        v.we = we; v.addr = addr; v.size = size; v.wdata = wdata; v.expRd = rd; v.expErr = err;
        return v;
    endfunction

    // Drive a request at a falling edge and hold it until a rising edge accepts it.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [2:0] size,
                                 input logic [31:0] wdata, input logic [31:0] expRd, input logic expErr,
                                 input bit push, output bit respAtAccept);
        int   waitCnt;
        exp_t e;
        waitCnt = 0;
        respAtAccept = 1'b0;
        @(negedge clk);
        reqWe    = we;
        reqAddr  = addr;
        reqSize  = size;
        reqWdata = wdata;
        reqValid = 1'b1;
        while (!reqReady && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!reqReady) begin
            compared++;
            mismatches++;
            $display("[TB] FAIL acceptTimeout: req_ready=%0b after %0d cycles, want 1", reqReady, waitCnt);
            reqValid = 1'b0;
            return;
        end
        respAtAccept = respValid;
        @(posedge clk);
        #1;
        if (push) begin
            e.rd  = expRd;
            e.err = expErr;
            e.cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic idleBus();
        @(negedge clk);
        reqValid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            compared++;
            mismatches++;
            $display("[TB] FAIL drainTimeout: %0d responses outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    // Every response is matched against the oldest outstanding expectation, including its arrival cycle.
    always @(negedge clk) begin
        if (respValid) begin
            if (sb.size() == 0) begin
                compared++;
                mismatches++;
                $display("[TB] FAIL unexpectedResp: resp_valid=1 rdata=0x%08h err=%0b, want no response", respRdata, respErr);
            end else begin
                monExp = sb.pop_front();
                checkOutput("respRdata", respRdata, monExp.rd);
                checkOutput("respErr", 32'(respErr), 32'(monExp.err));
                checkOutput("respLatency", 32'(cyc), 32'(monExp.cyc + LATENCY));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;

        vecs.push_back(mk(1, 32'h100,  3'b010, 32'hDEADBEEF, 32'h0,        0));
        vecs.push_back(mk(0, 32'h100,  3'b010, 32'h0,        32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 32'h100,  3'b000, 32'h0,        32'hFFFFFFEF, 0));
        vecs.push_back(mk(0, 32'h100,  3'b100, 32'h0,        32'h000000EF, 0));
        vecs.push_back(mk(0, 32'h102,  3'b001, 32'h0,        32'hFFFFDEAD, 0));
        vecs.push_back(mk(0, 32'h102,  3'b101, 32'h0,        32'h0000DEAD, 0));
        vecs.push_back(mk(1, 32'h101,  3'b000, 32'h12345677, 32'h0,        0));
        vecs.push_back(mk(0, 32'h100,  3'b010, 32'h0,        32'hDEAD77EF, 0));
        vecs.push_back(mk(1, 32'h104,  3'b010, 32'h44332255, 32'h0,        0));
        vecs.push_back(mk(0, 32'h101,  3'b010, 32'h0,        MIS_LW,       MIS_ERR));
        vecs.push_back(mk(0, 32'h103,  3'b001, 32'h0,        MIS_LH,       MIS_ERR));
        vecs.push_back(mk(0, MEM_BYTES - 2, 3'b010, 32'h0,   32'h0,        1));
        vecs.push_back(mk(1, MEM_BYTES - 1, 3'b000, 32'h000000A5, 32'h0,   0));
        vecs.push_back(mk(0, MEM_BYTES - 1, 3'b100, 32'h0,   32'h000000A5, 0));
        vecs.push_back(mk(0, MEM_BYTES - 1, 3'b000, 32'h0,   32'hFFFFFFA5, 0));
        vecs.push_back(mk(0, MEM_BYTES - 1, 3'b001, 32'h0,   32'h0,        1));
        vecs.push_back(mk(1, MEM_BYTES - 2, 3'b001, 32'h00008001, 32'h0,   0));
        vecs.push_back(mk(0, MEM_BYTES - 2, 3'b001, 32'h0,   32'hFFFF8001, 0));
        vecs.push_back(mk(1, MEM_BYTES - 4, 3'b010, 32'h0BADF00D, 32'h0,   0));
        vecs.push_back(mk(0, MEM_BYTES - 4, 3'b010, 32'h0,   32'h0BADF00D, 0));
        vecs.push_back(mk(1, 32'h100,  3'b100, 32'h00000000, 32'h0,        1));
        vecs.push_back(mk(1, 32'h100,  3'b011, 32'h00000000, 32'h0,        1));
        vecs.push_back(mk(0, 32'h100,  3'b011, 32'h0,        32'h0,        1));
        vecs.push_back(mk(0, 32'h100,  3'b110, 32'h0,        32'h0,        1));
        vecs.push_back(mk(0, 32'h100,  3'b010, 32'h0,        32'hDEAD77EF, 0));
        vecs.push_back(mk(0, 32'hFFFFFFFF, 3'b000, 32'h0,    32'h0,        1));
        vecs.push_back(mk(0, 32'hFFFFFFFE, 3'b010, 32'h0,    32'h0,        1));

        $display("[TB] reset phase");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("readyInReset", 32'(reqReady), 32'd0);
        checkOutput("respValidReset", 32'(respValid), 32'd0);
        checkOutput("respRdataReset", respRdata, 32'd0);
        checkOutput("respErrReset", 32'(respErr), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("readyAfterReset", 32'(reqReady), 32'd1);

        $display("[TB] vector table, %0d back-to-back requests", vecs.size());
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].wdata,
                          vecs[i].expRd, vecs[i].expErr, 1'b1, acc);
            if (i > 0) checkOutput("acceptOnRespCycle", 32'(acc), 32'd1);
        end
        idleBus();
        waitDrain();

        $display("[TB] reset during a pending store");
        applyStimulus(1'b1, 32'h200, 3'b010, 32'h11111111, 32'h0, 1'b0, 1'b1, acc);
        applyStimulus(1'b1, 32'h200, 3'b010, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, acc);
        @(negedge clk);
        reqValid = 1'b0;
        rst      = 1'b1;
        checkOutput("readyDuringAbort", 32'(reqReady), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        applyStimulus(1'b0, 32'h200, 3'b010, 32'h0, 32'h11111111, 1'b0, 1'b1, acc);
        idleBus();
        waitDrain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatches);
        $finish;
    end

endmodule
